// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the two-way write-back L1 data cache.
// Geometry is fixed: 8 sets, 2 ways, 16-byte lines.
package l1_dcache_pkg;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [127:0] lc3b_datbus;
  typedef logic [15:0]  lc3b_word;
  typedef logic [15:0]  lc3b_mask;

  typedef enum logic [1:0] {
    s_idle,
    s_writeback,
    s_allocate
  } dcache_state_e;

  localparam int unsigned NUM_SETS   = 8;
  localparam int unsigned LINE_BYTES = 16;

  function automatic lc3b_c_tag addr_tag(lc3b_word a);
    return a[15:7];
  endfunction

  function automatic lc3b_c_index addr_index(lc3b_word a);
    return a[6:4];
  endfunction

  function automatic lc3b_word line_addr(lc3b_c_tag t, lc3b_c_index i);
    return {t, i, 4'h0};
  endfunction

  // Byte i of the line is taken from new_line when mask[i] is set.
  function automatic lc3b_datbus merge_bytes(lc3b_datbus old_line, lc3b_datbus new_line,
                                             lc3b_mask mask);
    lc3b_datbus merged;
    merged = old_line;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_line[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// Request bundle from the memory stage plus the line-granular next-level memory handshake.
interface l1_dcache_if;
  import l1_dcache_pkg::*;

  logic       mem_req;
  logic       we_on_req;
  lc3b_word   addr;
  lc3b_datbus wdata;
  lc3b_mask   byte_en;
  logic       resp;
  lc3b_datbus rdata;

  logic       pmem_read;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_datbus pmem_wdata;
  logic       pmem_resp;
  lc3b_datbus pmem_rdata;

  modport master (
    output mem_req, we_on_req, addr, wdata, byte_en, pmem_resp, pmem_rdata,
    input  resp, rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_req, we_on_req, addr, wdata, byte_en, pmem_resp, pmem_rdata,
    output resp, rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/dcache_way.sv
// One cache way: 8 entries of valid/dirty/tag/line, asynchronous read, byte-masked synchronous write.
// Only the valid and dirty bits are cleared by reset; tag and data contents are left as-is.
module dcache_way
  import l1_dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  lc3b_c_index index,
  input  logic        data_write,
  input  lc3b_mask    mask,
  input  lc3b_datbus  data_in,
  input  logic        fill,
  input  logic        mark_dirty,
  input  lc3b_c_tag   tag_in,
  output logic        valid,
  output logic        dirty,
  output lc3b_c_tag   tag,
  output lc3b_datbus  data
);

  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;
  lc3b_c_tag           tags  [NUM_SETS];
  lc3b_datbus          lines [NUM_SETS];

  assign valid = valid_bits[index];
  assign dirty = dirty_bits[index];
  assign tag   = tags[index];
  assign data  = lines[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (mark_dirty) begin
      dirty_bits[index] <= 1'b1;
    end
  end

  // Reset wins over a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill) tags[index] <= tag_in;
      if (data_write) lines[index] <= merge_bytes(lines[index], data_in, mask);
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Two-way set-associative, write-back, write-allocate L1 data cache with per-set LRU.
// Hits complete combinationally in IDLE; misses walk WRITEBACK (dirty victim) and ALLOCATE.
module l1_dcache
  import l1_dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  l1_dcache_if.slave  bus
);

  dcache_state_e       state;
  logic [NUM_SETS-1:0] lru;
  lc3b_c_index         index;
  lc3b_c_index         miss_index;
  lc3b_c_index         way_index;
  lc3b_c_tag           tag;
  lc3b_c_tag           miss_tag;
  logic                victim_way;
  logic                cur_victim;
  logic                lookup;
  logic                any_hit;
  logic                hit_way;

  logic                pmem_read;
  logic                pmem_write;
  lc3b_word            pmem_address;
  lc3b_datbus          pmem_wdata;

  logic [1:0]          valid;
  logic [1:0]          dirty;
  logic [1:0]          hit;
  logic [1:0]          fill;
  logic [1:0]          hit_write;
  lc3b_c_tag           way_tag  [2];
  lc3b_datbus          way_data [2];

  logic                unused_offset;
  assign unused_offset = ^bus.addr[3:0];

  assign tag        = addr_tag(bus.addr);
  assign index      = addr_index(bus.addr);
  // During a miss the request may drop or move, so the arrays follow the latched miss set.
  assign way_index  = (state == s_idle) ? index : miss_index;
  assign lookup     = (state == s_idle) && bus.mem_req;
  assign any_hit    = |hit;
  assign hit_way    = hit[1];
  assign cur_victim = lru[index];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit[w]       = valid[w] && (way_tag[w] == tag);
    assign fill[w]      = (state == s_allocate) && bus.pmem_resp && (victim_way == 1'(w)) && !rst;
    assign hit_write[w] = lookup && bus.we_on_req && hit[w] && !rst;

    dcache_way u_way (
      .clk        (clk),
      .rst        (rst),
      .index      (way_index),
      .data_write (fill[w] | hit_write[w]),
      .mask       (fill[w] ? 16'hFFFF : bus.byte_en),
      .data_in    (fill[w] ? bus.pmem_rdata : bus.wdata),
      .fill       (fill[w]),
      .mark_dirty (hit_write[w]),
      .tag_in     (miss_tag),
      .valid      (valid[w]),
      .dirty      (dirty[w]),
      .tag        (way_tag[w]),
      .data       (way_data[w])
    );
  end

  assign bus.resp         = lookup && any_hit;
  assign bus.rdata        = hit_way ? way_data[1] : way_data[0];
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_address = pmem_address;
  assign bus.pmem_wdata   = pmem_wdata;

  // Memory-side outputs are registered on each transition so they stay stable until pmem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= s_idle;
      lru        <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (bus.mem_req) begin
            if (any_hit) begin
              lru[index] <= ~hit_way;
            end else begin
              miss_index <= index;
              miss_tag   <= tag;
              victim_way <= cur_victim;
              if (valid[cur_victim] && dirty[cur_victim]) begin
                state        <= s_writeback;
                pmem_write   <= 1'b1;
                pmem_address <= line_addr(way_tag[cur_victim], index);
                pmem_wdata   <= way_data[cur_victim];
              end else begin
                state        <= s_allocate;
                pmem_read    <= 1'b1;
                pmem_address <= line_addr(tag, index);
              end
            end
          end
        end
        s_writeback: begin
          if (bus.pmem_resp) begin
            state        <= s_allocate;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= line_addr(miss_tag, miss_index);
          end
        end
        s_allocate: begin
          if (bus.pmem_resp) begin
            state     <= s_idle;
            pmem_read <= 1'b0;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: hit vectors from a table plus hand-written miss, eviction,
// LRU and reset sequences with a bench-driven next-level memory.
module tb_l1_dcache;
  import l1_dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_dcache_if bus ();

  l1_dcache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  localparam lc3b_datbus LINE_L   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam lc3b_datbus LINE_LM  = 128'h0123456789ABCDEF_FEDCBEEF76543210;
  localparam lc3b_datbus LINE_LM2 = 128'h0123456789ABCDEF_FEDCBEEF765432FF;
  localparam lc3b_datbus LINE_M   = 128'hAAAA5555_CAFEF00D_DEADBEEF_13572468;
  localparam lc3b_datbus LINE_N   = 128'h55550000_11112222_33334444_66667777;
  localparam lc3b_datbus LINE_P   = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;

  typedef struct {
    logic       we;
    lc3b_word   addr;
    lc3b_datbus wdata;
    lc3b_mask   byte_en;
    lc3b_datbus exp_rdata;
    string      name;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input lc3b_word a,
                               input lc3b_datbus wd, input lc3b_mask be);
    bus.mem_req   = req;
    bus.we_on_req = we;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.byte_en   = be;
  endtask

  task automatic doReset();
    rst            = 1'b1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called just after a rising edge; presents a request that must hit, then drops it.
  task automatic hitAccess(input logic we, input lc3b_word a, input lc3b_datbus wd,
                           input lc3b_mask be, input lc3b_datbus exp, input string name);
    applyStimulus(1'b1, we, a, wd, be);
    @(negedge clk);
    checkOutput({name, " resp"}, 128'(bus.resp), 128'd1);
    checkOutput({name, " rdata"}, bus.rdata, exp);
    checkOutput({name, " pmem idle"}, 128'({bus.pmem_read, bus.pmem_write}), 128'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 16'h0, '0, '0);
  endtask

  // Waits for a memory request, checks it, holds it for delay cycles, then pulses pmem_resp.
  task automatic serviceMiss(input logic is_wb, input lc3b_word exp_addr,
                             input lc3b_datbus exp_wdata, input lc3b_datbus fill_line,
                             input int delay, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.pmem_read | bus.pmem_write;
    end
    if (!found) begin
      checkOutput({name, " request timeout"}, 128'd0, 128'd1);
      return;
    end
    checkOutput({name, " pmem_write"}, 128'(bus.pmem_write), 128'(is_wb));
    checkOutput({name, " pmem_read"}, 128'(bus.pmem_read), 128'(!is_wb));
    checkOutput({name, " pmem_address"}, 128'(bus.pmem_address), 128'(exp_addr));
    if (is_wb) checkOutput({name, " pmem_wdata"}, bus.pmem_wdata, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput({name, " held address"}, 128'(bus.pmem_address), 128'(exp_addr));
      checkOutput({name, " held strobes"}, 128'({bus.pmem_read, bus.pmem_write}),
                  128'({!is_wb, is_wb}));
      checkOutput({name, " no resp while waiting"}, 128'(bus.resp), 128'd0);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = fill_line;
    #1 checkOutput({name, " no resp with pmem_resp"}, 128'(bus.resp), 128'd0);
    @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  task automatic missAccess(input lc3b_word a, input logic has_wb, input lc3b_word wb_addr,
                            input lc3b_datbus wb_line, input lc3b_datbus fill_line,
                            input int delay, input string name);
    lc3b_word fill_addr;
    fill_addr = {a[15:4], 4'h0};
    applyStimulus(1'b1, 1'b0, a, '0, '0);
    @(negedge clk);
    checkOutput({name, " miss has no resp"}, 128'(bus.resp), 128'd0);
    if (has_wb) serviceMiss(1'b1, wb_addr, wb_line, '0, 0, {name, " writeback"});
    serviceMiss(1'b0, fill_addr, '0, fill_line, delay, {name, " fill"});
    @(negedge clk);
    checkOutput({name, " resp after fill"}, 128'(bus.resp), 128'd1);
    checkOutput({name, " rdata after fill"}, bus.rdata, fill_line);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 16'h0, '0, '0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h1236, '0, 16'hFFFF, LINE_L, "read hit 0x1236"};
    vecs[1] = '{1'b1, 16'h1234, {8{16'hBEEF}}, 16'h0030, LINE_L, "write hit word2"};
    vecs[2] = '{1'b0, 16'h1230, '0, 16'h0000, LINE_LM, "read merged line"};
    vecs[3] = '{1'b1, 16'h123F, {16{8'hFF}}, 16'h0001, LINE_LM, "write hit byte0"};
    vecs[4] = '{1'b0, 16'h1231, {16{8'h11}}, 16'hFFFF, LINE_LM2, "read ignores byte_en"};

    doReset();
    @(negedge clk);
    checkOutput("reset resp", 128'(bus.resp), 128'd0);
    checkOutput("reset pmem_read", 128'(bus.pmem_read), 128'd0);
    checkOutput("reset pmem_write", 128'(bus.pmem_write), 128'd0);
    @(posedge clk);
    #1;

    missAccess(16'h1234, 1'b0, 16'h0, '0, LINE_L, 3, "cold read");
    for (int i = 0; i < 5; i++)
      hitAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].byte_en,
                vecs[i].exp_rdata, vecs[i].name);

    // A request held past resp is a fresh access and hits again.
    applyStimulus(1'b1, 1'b0, 16'h1238, '0, '0);
    @(negedge clk);
    checkOutput("held read first resp", 128'(bus.resp), 128'd1);
    @(negedge clk);
    checkOutput("held read second resp", 128'(bus.resp), 128'd1);
    checkOutput("held read rdata", bus.rdata, LINE_LM2);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 16'h0, '0, '0);

    missAccess(16'h1330, 1'b0, 16'h0, '0, LINE_M, 0, "fill 0x1330");
    missAccess(16'h1430, 1'b1, 16'h1230, LINE_LM2, LINE_N, 1, "dirty evict");

    doReset();
    @(posedge clk);
    #1;
    missAccess(16'h1230, 1'b0, 16'h0, '0, LINE_L, 0, "lru fill 0x1230");
    missAccess(16'h1330, 1'b0, 16'h0, '0, LINE_M, 0, "lru fill 0x1330");
    hitAccess(1'b0, 16'h1230, '0, '0, LINE_L, "lru rehit 0x1230");
    missAccess(16'h1430, 1'b0, 16'h0, '0, LINE_N, 0, "lru clean evict");
    hitAccess(1'b0, 16'h1230, '0, '0, LINE_L, "lru survivor 0x1230");
    missAccess(16'h1330, 1'b0, 16'h0, '0, LINE_M, 0, "lru evicted 0x1330");

    // Reset lands together with the fill response; the fill must not take effect.
    applyStimulus(1'b1, 1'b0, 16'h2040, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("mid-fill pmem_read", 128'(bus.pmem_read), 128'd1);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_N;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, '0);
    @(negedge clk);
    checkOutput("after rst pmem_read", 128'(bus.pmem_read), 128'd0);
    checkOutput("after rst pmem_write", 128'(bus.pmem_write), 128'd0);
    @(posedge clk);
    #1;
    missAccess(16'h2040, 1'b0, 16'h0, '0, LINE_P, 10, "refill after rst slow");

    // A stray pmem_resp while idle must not disturb the cache.
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_N;
    @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    hitAccess(1'b0, 16'h2044, '0, '0, LINE_P, "idle pmem_resp ignored");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Two-way set-associative, write-back, write-allocate L1 data cache sitting directly downstream of the CPU datapath's memory stage. It consumes the `dcache_*` request bundle: line-wide write data plus a 16-bit byte-enable mask. It returns a full 128-bit line with a one-cycle response pulse. Misses are serviced from the next memory level over a line-granular physical-memory handshake.

## Interface
Parameters:
- None. Geometry is fixed: 8 sets, 2 ways, 16-byte lines; index = addr[6:4], tag = addr[15:7], offset = addr[3:0].

Ports:
- `clk`  in  1  sole clock; everything is posedge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  request valid. Held high, with addr/we/wdata/byte_en stable, until `resp`.
- `we_on_req`  in  1  1 = write, 0 = read.
- `addr`  in  16  byte address; offset bits are ignored for tag/index.
- `wdata`  in  128  line-positioned write data.
- `byte_en`  in  16  bit i enables line byte i (bits 8i+7:8i); ignored on reads.
- `resp`  out  1  one-cycle completion pulse.
- `rdata`  out  128  hit line; valid while `resp`=1.
- `pmem_read`  out  1  line fill request.
- `pmem_write`  out  1  line writeback request.
- `pmem_address`  out  16  line-aligned address, low 4 bits = 0.
- `pmem_wdata`  out  128  victim line.
- `pmem_resp`  in  1  next-level completion pulse.
- `pmem_rdata`  in  128  fill data; valid with `pmem_resp`.

## Operation
- Per way and set: valid, dirty, 9-bit tag, 128-bit data. Per set: 1 LRU bit naming the way to evict.
- The FSM has three states.
- **IDLE** (compare):
  - With `mem_req` and a tag match on a valid way, assert `resp` combinationally.
  - Read: `rdata` = hit line.
  - Write: bytes with `byte_en`=1 are written at the clock edge, and the way's dirty bit is set.
  - On any hit, LRU is set to the other way.
  - With `mem_req` and a miss, the victim is the LRU way. A valid, dirty victim goes to WRITEBACK; otherwise go to ALLOCATE.
- **WRITEBACK**:
  - `pmem_write`=1, `pmem_address`={victim tag, index, 4'h0}, `pmem_wdata`=victim data.
  - On `pmem_resp`, go to ALLOCATE.
- **ALLOCATE**:
  - `pmem_read`=1, `pmem_address`={addr tag, index, 4'h0}.
  - On `pmem_resp`, write `pmem_rdata` into the victim way and set valid=1, dirty=0, tag=addr tag. Then return to IDLE.
  - The request then hits and completes as above. Write misses merge in that hit cycle.
- `pmem_read` and `pmem_write` are never both high.
- `pmem_resp` in IDLE is ignored.

## Timing
- Reset values:
  - `resp`=0, `pmem_read`=0, `pmem_write`=0.
  - All valid, dirty and LRU bits = 0; state = IDLE.
  - `rdata`, `pmem_address` and `pmem_wdata` are don't-care. Data and tag arrays are not reset.
- Hit latency: 0 cycles. `resp` is high in the same cycle the request is presented in IDLE.
- Clean miss: `resp` arrives 1 cycle after the fill's `pmem_resp`.
- Dirty miss: writeback, then fill, then 1 cycle.
- The requester must drop or change `mem_req` in the cycle after `resp`. A held request is treated as a new access and hits again.
- While in WRITEBACK/ALLOCATE, `pmem_*` outputs stay stable until `pmem_resp`, with no timeout.
- If `mem_req` drops mid-miss, the current writeback/fill still completes; no `resp` is issued.
- `rst` mid-miss: `pmem_read`/`pmem_write` are 0 from the next cycle. The abandoned transaction leaves no line valid.
- `rst` has priority over any concurrent `pmem_resp` or hit write.

## Structure
- Add to lc3b_types:
  - `lc3b_c_tag` (9 bits) and `lc3b_c_index` (3 bits).
  - Reuse `lc3b_datbus` (128-bit) and `lc3b_word`.
  - A state enum `{ s_idle, s_writeback, s_allocate }`.
- One sub-module, `dcache_way`, instantiated twice. It holds the 8-entry data/tag/valid/dirty arrays with async read, a sync byte-masked write, and a sync `rst` clear of valid/dirty.
- LRU bits, hit/victim logic and the FSM live in `l1_dcache`.

## Test plan
- **Cold read:** after reset, read 0x1234.
  - Required: `pmem_read`=1 with `pmem_address`=0x1230; respond with line L after 3 cycles.
  - Required: `resp` arrives one cycle after `pmem_resp`, with `rdata`=L.
  - Then read 0x1236: `resp` in the same cycle, no pmem activity.
- **Write hit:** write 0x1234 with `byte_en`=0x0030 and `wdata`={8{16'hBEEF}}.
  - Required: `resp` in the same cycle.
  - Required: reading 0x1230 returns L with word 2 = 0xBEEF and the other words unchanged.
- **Dirty eviction:** with 0x1230 dirty, read 0x1330, then 0x1430 (all index 3; tags 0x24/0x26/0x28).
  - Required: `pmem_write` to 0x1230 with the merged line.
  - Required: then `pmem_read` of 0x1430, then `resp`.
- **LRU order:** fresh reset; read 0x1230, then 0x1330, re-read 0x1230, then read 0x1430.
  - Required: 0x1330 is evicted, with no writeback because it is clean.
  - Required: re-reading 0x1230 hits.
- **Reset mid-fill:** assert `rst` for 1 cycle during ALLOCATE.
  - Required: `pmem_read`=0 on the next cycle.
  - Required: re-reading the same address misses again.
- **Slow memory:** delay `pmem_resp` by 10 cycles.
  - Required: `pmem_read`/`pmem_address` stay stable and `resp` stays 0 throughout.
